// File: rtl/pkt_parser_pkg.sv
// pkt_parser_pkg: shared state encoding, stage-bit indices and default sizing
// for the packet parser front end.
package pkt_parser_pkg;
  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } seq_state_t;
  localparam int STG_HDR0 = 0;
  localparam int STG_HDR1 = 1;
  localparam int STG_HDR2 = 2;
  localparam int STG_COMMIT = 3;
  localparam int STG_STALL = 4;
  localparam int STAGE_W = 5;
  localparam int HEADER_BEATS = 3;
endpackage

// File: rtl/sat_beat_counter.sv
// sat_beat_counter: beat counter that loads 1 on a packet's first beat,
// increments on later beats and saturates at all-ones.
module sat_beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(1);
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/packet_stage_sequencer.sv
// packet_stage_sequencer: watches the ingress FIFO handshake and emits header
// stage strobes, metadata commit, stall, beat count and done/runt pulses.
// Optional runt_err port is built when PKT_SEQ_RUNT_EN is defined.
module packet_stage_sequencer #(
  parameter int HEADER_BEATS = pkt_parser_pkg::HEADER_BEATS,
  parameter int STAGE_W = pkt_parser_pkg::STAGE_W,
  parameter int BEAT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  input  logic                  s_tready,
  input  logic                  s_tlast,
  output logic [STAGE_W-1:0]    stage_ready,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output logic                  pkt_done
`ifdef PKT_SEQ_RUNT_EN
  ,
  output logic                  runt_err
`endif
);
  import pkt_parser_pkg::*;
  localparam logic [1:0] HDR_LAST = 2'(HEADER_BEATS - 1);
  seq_state_t state_q, state_d;
  logic [1:0] hdr_idx, idx_d;
  logic fire, last_hdr_beat, commit_q, done_q;
  logic [STAGE_W-1:0] strobes;
  assign fire = s_tvalid & s_tready;
  assign last_hdr_beat = (state_q == IDLE && HEADER_BEATS == 1) ||
                         (state_q == HDR && hdr_idx == HDR_LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      hdr_idx  <= '0;
      commit_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_idx  <= idx_d;
      commit_q <= fire & last_hdr_beat;
      done_q   <= fire & s_tlast;
    end
  always_comb begin
    state_d = state_q;
    idx_d   = hdr_idx;
    if (fire)
      unique case (state_q)
        IDLE: begin
          state_d = s_tlast ? IDLE : (HEADER_BEATS > 1 ? HDR : PAYLOAD);
          idx_d   = (!s_tlast && HEADER_BEATS > 1) ? 2'd1 : 2'd0;
        end
        HDR: begin
          state_d = s_tlast ? IDLE : (hdr_idx == HDR_LAST ? PAYLOAD : HDR);
          idx_d   = (s_tlast || hdr_idx == HDR_LAST) ? 2'd0 : hdr_idx + 2'd1;
        end
        PAYLOAD: state_d = s_tlast ? IDLE : PAYLOAD;
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end
      endcase
  end
  // Header strobes are zero-latency so the parser samples the beat it is on;
  // everything is forced low while reset is held.
  always_comb begin
    strobes = '0;
    strobes[STG_HDR0] = fire && state_q == IDLE;
    for (int k = 1; k < 3; k++)
      if (k < HEADER_BEATS) strobes[k] = fire && state_q == HDR && hdr_idx == 2'(k);
    strobes[STG_COMMIT] = commit_q;
    strobes[STG_STALL]  = s_tvalid && !s_tready && state_q != IDLE;
    stage_ready = rst ? '0 : strobes;
  end
  assign pkt_done = done_q;
  sat_beat_counter #(.W(BEAT_CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(fire && state_q == IDLE),
    .inc (fire && state_q != IDLE),
    .cnt (beat_cnt)
  );
`ifdef PKT_SEQ_RUNT_EN
  // A tlast before the final header beat is a runt; payload tlasts never are.
  always_ff @(posedge clk or posedge rst)
    if (rst) runt_err <= 1'b0;
    else runt_err <= fire & s_tlast & (state_q != PAYLOAD) & ~last_hdr_beat;
`endif
endmodule

// File: tb/tb_packet_stage_sequencer.sv
// tb_packet_stage_sequencer: directed scenarios for packet_stage_sequencer,
// with a second instance using a 4-bit beat counter to exercise saturation.
module tb_packet_stage_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0;
  logic [4:0] sr, sr2;
  logic [15:0] cnt;
  logic [3:0] cnt2;
  logic done, done2;
  logic [4:0] o_sr;
  logic [15:0] o_cnt;
  logic [3:0] o_sat;
  logic o_done, o_sat_done, o_runt;
  int tests = 0, fails = 0;
`ifdef PKT_SEQ_RUNT_EN
  logic runt, runt2;
`endif

  always #5 clk = ~clk;

  packet_stage_sequencer dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .stage_ready(sr), .beat_cnt(cnt), .pkt_done(done)
`ifdef PKT_SEQ_RUNT_EN
    , .runt_err(runt)
`endif
  );

  packet_stage_sequencer #(.BEAT_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .stage_ready(sr2), .beat_cnt(cnt2), .pkt_done(done2)
`ifdef PKT_SEQ_RUNT_EN
    , .runt_err(runt2)
`endif
  );

  // Drive one cycle's inputs, sample all outputs mid-cycle, then move to the next cycle.
  task automatic apply(input logic v, input logic r, input logic l);
    s_tvalid = v;
    s_tready = r;
    s_tlast  = l;
    #2;
    o_sr = sr;
    o_cnt = cnt;
    o_done = done;
    o_sat = cnt2;
    o_sat_done = done2;
`ifdef PKT_SEQ_RUNT_EN
    o_runt = runt;
`else
    o_runt = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (sr !== 5'd0 || cnt !== 16'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: sr=%b cnt=%0d done=%b expected 0/0/0", sr, cnt, done);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_packet;
    int e_sr[6] = '{1, 2, 4, 8, 0, 0};
    int e_cnt[6] = '{0, 1, 2, 3, 4, 5};
    int e_done[6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) apply(1'b1, 1'b1, i == 4);
      else apply(1'b0, 1'b0, 1'b0);
      tests++;
      if (o_sr !== 5'(e_sr[i]) || o_cnt !== 16'(e_cnt[i]) || o_done !== 1'(e_done[i])) begin
        fails++;
        $display("FAIL packet c%0d: sr=%b cnt=%0d done=%b expected %b/%0d/%0d",
                 i, o_sr, o_cnt, o_done, 5'(e_sr[i]), e_cnt[i], e_done[i]);
      end
    end
  endtask

  task automatic test_stall;
    int v[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int r[8] = '{1, 0, 0, 1, 1, 1, 1, 0};
    int l[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int e_sr[8] = '{1, 16, 16, 2, 4, 8, 0, 0};
    int e_cnt[8] = '{5, 1, 1, 1, 2, 3, 4, 5};
    int e_done[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      apply(1'(v[i]), 1'(r[i]), 1'(l[i]));
      tests++;
      if (o_sr !== 5'(e_sr[i]) || o_cnt !== 16'(e_cnt[i]) || o_done !== 1'(e_done[i])) begin
        fails++;
        $display("FAIL stall c%0d: sr=%b cnt=%0d done=%b expected %b/%0d/%0d",
                 i, o_sr, o_cnt, o_done, 5'(e_sr[i]), e_cnt[i], e_done[i]);
      end
    end
  endtask

  task automatic test_runt;
    int e_sr[4] = '{1, 2, 0, 0};
    int e_cnt[4] = '{5, 1, 2, 2};
    int e_done[4] = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      if (i < 2) apply(1'b1, 1'b1, i == 1);
      else apply(1'b0, 1'b0, 1'b0);
      tests++;
      if (o_sr !== 5'(e_sr[i]) || o_cnt !== 16'(e_cnt[i]) || o_done !== 1'(e_done[i])) begin
        fails++;
        $display("FAIL runt c%0d: sr=%b cnt=%0d done=%b expected %b/%0d/%0d",
                 i, o_sr, o_cnt, o_done, 5'(e_sr[i]), e_cnt[i], e_done[i]);
      end
`ifdef PKT_SEQ_RUNT_EN
      tests++;
      if (o_runt !== 1'(e_done[i])) begin
        fails++;
        $display("FAIL runt_err c%0d: got %b expected %0d", i, o_runt, e_done[i]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    int e_sr[8] = '{1, 2, 4, 9, 2, 4, 8, 0};
    int e_cnt[8] = '{2, 1, 2, 3, 1, 2, 3, 3};
    int e_done[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) apply(1'b1, 1'b1, i == 2 || i == 5);
      else apply(1'b0, 1'b0, 1'b0);
      tests++;
      if (o_sr !== 5'(e_sr[i]) || o_cnt !== 16'(e_cnt[i]) || o_done !== 1'(e_done[i])) begin
        fails++;
        $display("FAIL b2b c%0d: sr=%b cnt=%0d done=%b expected %b/%0d/%0d",
                 i, o_sr, o_cnt, o_done, 5'(e_sr[i]), e_cnt[i], e_done[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    apply(1'b1, 1'b1, 1'b0);
    s_tvalid = 1'b1;
    s_tready = 1'b1;
    s_tlast  = 1'b0;
    rst = 1'b1;
    #2;
    tests++;
    if (sr !== 5'd0 || cnt !== 16'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: sr=%b cnt=%0d done=%b expected 0/0/0", sr, cnt, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(1'b1, 1'b1, 1'b0);
    tests++;
    if (o_sr !== 5'b00001 || o_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_beat0: sr=%b cnt=%0d expected 00001/0", o_sr, o_cnt);
    end
    apply(1'b1, 1'b1, 1'b1);
    tests++;
    if (o_sr !== 5'b00010 || o_cnt !== 16'd1) begin
      fails++;
      $display("FAIL reset_mid_beat1: sr=%b cnt=%0d expected 00010/1", o_sr, o_cnt);
    end
    apply(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_done !== 1'b1 || o_cnt !== 16'd2) begin
      fails++;
      $display("FAIL reset_mid_done: done=%b cnt=%0d expected 1/2", o_done, o_cnt);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 19; i++) begin
      if (i < 18) apply(1'b1, 1'b1, i == 17);
      else apply(1'b0, 1'b0, 1'b0);
      if (i == 15 || i == 16 || i == 17) begin
        tests++;
        if (o_sat !== 4'd15 || o_sat_done !== 1'b0) begin
          fails++;
          $display("FAIL sat c%0d: cnt=%0d done=%b expected 15/0", i, o_sat, o_sat_done);
        end
      end
    end
    tests++;
    if (o_sat !== 4'd15 || o_sat_done !== 1'b1) begin
      fails++;
      $display("FAIL sat_end: cnt=%0d done=%b expected 15/1", o_sat, o_sat_done);
    end
    tests++;
    if (o_cnt !== 16'd18 || o_done !== 1'b1) begin
      fails++;
      $display("FAIL wide_end: cnt=%0d done=%b expected 18/1", o_cnt, o_done);
    end
  endtask

  initial begin
    test_reset;
    test_packet;
    test_stall;
    test_runt;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/packet_stage_sequencer.md
# packet_stage_sequencer

- Tracks AXI-Stream beats leaving the ingress FIFO.
- Produces the per-beat stage strobe vector `stage_ready` that drives `header_parser`:
  - bits 0..2 are the header stage valids.
  - bit 3 is the metadata commit pulse.
  - bit 4 is the stall.
- Sits between the FIFO read port and `header_parser`. It observes the FIFO handshake and never drives it.
- Also counts packet length in beats and flags runt packets.

## Interface
- `HEADER_BEATS`, default 3: number of header beats; strobes exist for beats 0..HEADER_BEATS-1. Legal range is 1..3.
- `STAGE_W`, default 5: width of `stage_ready`.
- `BEAT_CNT_W`, default 16: width of the beat counter.
- `clk` in 1: single clock. All state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_tvalid` in 1: FIFO output tvalid.
- `s_tready` in 1: consumer tready at the FIFO output.
- `s_tlast` in 1: FIFO output tlast.
- `stage_ready` out STAGE_W: bit k (k < HEADER_BEATS) is header beat k valid; bit 3 is the metadata commit; bit 4 is the stall.
- `beat_cnt` out BEAT_CNT_W: beats accepted so far in the current packet.
- `pkt_done` out 1: one-cycle pulse after a tlast beat is accepted.
- `runt_err` out 1: one-cycle runt pulse. Only exists when `PKT_SEQ_RUNT_EN` is defined.

## Operation
- `fire` = `s_tvalid & s_tready`.
- FSM states:
  - `IDLE`: waiting for beat 0 of a packet.
  - `HDR`: header beats 1..HEADER_BEATS-1, tracked by `hdr_idx`.
  - `PAYLOAD`: post-header beats until tlast.
- `IDLE` transitions on `fire`:
  - `s_tlast`=0 and HEADER_BEATS>1 → `HDR`, `hdr_idx`=1.
  - `s_tlast`=0 and HEADER_BEATS=1 → `PAYLOAD`.
  - `s_tlast`=1 and HEADER_BEATS>1 → runt; stay in `IDLE`.
  - `s_tlast`=1 and HEADER_BEATS=1 → complete single-beat packet; stay in `IDLE`.
- `HDR` transitions on `fire`:
  - If `hdr_idx`=HEADER_BEATS-1: go to `IDLE` if `s_tlast`, otherwise to `PAYLOAD`.
  - Else if `s_tlast`: runt; go to `IDLE`.
  - Else: increment `hdr_idx`.
- `PAYLOAD` on `fire & s_tlast` → `IDLE`.
- `stage_ready[k]`, for k < HEADER_BEATS:
  - Combinational: `fire` & (`IDLE` if k=0, else `HDR` with `hdr_idx`=k).
  - It asserts in the same cycle the beat is on `tdata`, so the parser samples `header_slice` then.
  - Bits k ≥ HEADER_BEATS, below bit 3, are tied to 0.
- `stage_ready[3]`: registered. Pulses one cycle after the last header beat fires. Never pulses for a runt.
- `stage_ready[4]` (stall): combinational, `s_tvalid & ~s_tready` while not in `IDLE`. The parser holds its partial metadata while it is high.
- `beat_cnt`:
  - Registered. Takes the value 1 on a beat-0 `fire`; increments on every later `fire` in the packet.
  - Saturates at all-ones and does not wrap.
  - Holds its final value after tlast until the next beat-0 `fire`.
- `pkt_done`: registered pulse one cycle after any `fire & s_tlast`, including runts.
- Back-to-back packets (tlast fire followed immediately by the next beat-0 fire) need no idle gap.

## Timing
- Reset values: state `IDLE`, `hdr_idx`=0, `beat_cnt`=0. `stage_ready`, `pkt_done` and `runt_err` are 0.
- Latency:
  - Header strobes: 0 cycles.
  - Commit, `pkt_done`, `runt_err`: 1 cycle.
  - `beat_cnt` update: 1 cycle.
- Reset asserted mid-packet: return to `IDLE` immediately; pending commit and pulses are cleared. The next fired beat is treated as beat 0, even if it is mid-packet upstream.
- `s_tvalid` without `s_tready`: no state change and no strobe; stall is asserted if not in `IDLE`.
- `s_tready` without `s_tvalid`: no effect.

## Configuration
- `PKT_SEQ_RUNT_EN`:
  - Defined: the `runt_err` port exists and pulses one cycle after a tlast fire that occurs before the last header beat.
  - Undefined: the port is absent and runts silently return the FSM to `IDLE`. In both cases no commit is issued for a runt.

## Structure
- Shared package `pkt_parser_pkg` holds:
  - The state enum `seq_state_t`.
  - Stage bit indices `STG_HDR0`, `STG_HDR1`, `STG_HDR2`, `STG_COMMIT`, `STG_STALL`.
  - The constants `STAGE_W` and `HEADER_BEATS`.
- Beat counting lives in one sub-module, `sat_beat_counter`: load-1, increment and saturate.

## Test plan
- 5-beat packet, s_tready=1 throughout:
  - `stage_ready[0]`, `[1]`, `[2]` are high in cycles 0, 1, 2.
  - `stage_ready[3]` is high in cycle 3.
  - `pkt_done` is high in cycle 5; `beat_cnt`=5.
- Same packet with s_tready=0 for 2 cycles during beat 1: `stage_ready[4]` is high for those 2 cycles, no `stage_ready[1]` during them, and strobes resume in order afterwards.
- 2-beat runt (tlast on beat 1):
  - `stage_ready[3]` never pulses.
  - `runt_err` and `pkt_done` pulse once when `PKT_SEQ_RUNT_EN` is defined; only `pkt_done` pulses otherwise.
- Back-to-back 3-beat packets: two commits 3 cycles apart, and the second `stage_ready[0]` fires in the cycle after the first tlast.
- Reset asserted during beat 1: all outputs are 0 immediately, and the next fire produces `stage_ready[0]`.
- Force `beat_cnt` to saturate with BEAT_CNT_W=4 and an 18-beat packet: `beat_cnt` holds at 15 and `pkt_done` still pulses.
